// File: rtl/hamming_pkg.sv
// Shared Hamming(12,8) definitions: widths, parity masks and the syndrome/extract helpers.
// The encoder builds its parity bits from the same masks, so both ends agree by construction.
package hamming_pkg;

  localparam int CW_W   = 12;
  localparam int DATA_W = 8;
  localparam int SYN_W  = 4;

  // Mask i selects every codeword position whose 1-based index has bit i set.
  localparam logic [CW_W-1:0] PARITY_MASK [SYN_W] = '{
    12'h555,
    12'h666,
    12'h878,
    12'hF80
  };

  function automatic logic [SYN_W-1:0] hamming_syndrome(input logic [CW_W-1:0] cw);
    logic [SYN_W-1:0] syn;
    syn = '0;
    for (int i = 0; i < SYN_W; i++) begin
      syn[i] = ^(cw & PARITY_MASK[i]);
    end
    return syn;
  endfunction

  function automatic logic [DATA_W-1:0] hamming_extract(input logic [CW_W-1:0] cw);
    return {cw[11:8], cw[6:4], cw[2]};
  endfunction

endpackage

// File: rtl/hamming_err_counter.sv
// Saturating event counter; clear wins over a same-edge increment.
module hamming_err_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hamming_decoder.sv
// Two-stage Hamming(12,8) SEC decoder: stage 1 registers word and syndrome,
// stage 2 corrects, extracts data and raises the error flags.
module hamming_decoder
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic              in_valid,
  input  logic [CW_W-1:0]   hc_in,
  input  logic              cnt_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              err_corr,
  output logic              err_uncorr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  // Handshake: in_valid and data_valid are pure valid qualifiers with no ready.
  // Every cycle with in_valid=1 yields exactly one data_valid pulse two edges later.

  logic              s1_valid;
  logic [CW_W-1:0]   s1_cw;
  logic [SYN_W-1:0]  s1_syn;

  logic              is_corr;
  logic              is_uncorr;
  logic              set_corr;
  logic              set_uncorr;
  logic [CW_W-1:0]   fixed_cw;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
      s1_syn   <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_cw  <= hc_in;
        s1_syn <= hamming_syndrome(hc_in);
      end
    end
  end

  // Syndromes 13..15 point past the codeword, so they can only come from multi-bit errors.
  always_comb begin
    is_corr   = (s1_syn != '0) && (s1_syn <= 4'd12);
    is_uncorr = (s1_syn >= 4'd13);
    fixed_cw  = s1_cw;
    if (is_corr) begin
      fixed_cw = s1_cw ^ (12'(1) << (s1_syn - 4'd1));
    end
    set_corr   = s1_valid && is_corr;
    set_uncorr = s1_valid && is_uncorr;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      err_corr   <= 1'b0;
      err_uncorr <= 1'b0;
    end else begin
      data_valid <= s1_valid;
      err_corr   <= set_corr;
      err_uncorr <= set_uncorr;
      if (s1_valid) begin
        data_out <= hamming_extract(fixed_cw);
      end
    end
  end

  hamming_err_counter #(.CNT_W(CNT_W)) u_corr_cnt (
    .clk   (clk),
    .arstn (arstn),
    .inc   (set_corr),
    .clr   (cnt_clr),
    .count (corr_cnt)
  );

  hamming_err_counter #(.CNT_W(CNT_W)) u_uncorr_cnt (
    .clk   (clk),
    .arstn (arstn),
    .inc   (set_uncorr),
    .clr   (cnt_clr),
    .count (uncorr_cnt)
  );

endmodule

// File: tb/tb_hamming_decoder.sv
// Bench for hamming_decoder: directed steps, a scoreboard of due-cycle-tagged expected words,
// and independent saturating counter models for a 16-bit and a 2-bit counter instance.
module tb_hamming_decoder;

  logic        clk;
  logic        arstn;
  logic        in_valid;
  logic [11:0] hc_in;
  logic        cnt_clr;

  logic [7:0]  data_out,   data_out_s;
  logic        data_valid, data_valid_s;
  logic        err_corr,   err_corr_s;
  logic        err_uncorr, err_uncorr_s;
  logic [15:0] corr_cnt,   uncorr_cnt;
  logic [1:0]  corr_cnt_s, uncorr_cnt_s;

  // Entry layout: [25:10] due cycle, [9] corr, [8] uncorr, [7:0] data
  logic [25:0] exp_q[$];
  int          checks;
  int          errors;
  int          cyc;
  int          m_corr16, m_unc16, m_corr2, m_unc2;
  logic [7:0]  last_data;

  hamming_decoder #(.CNT_W(16)) dut (
    .clk        (clk),
    .arstn      (arstn),
    .in_valid   (in_valid),
    .hc_in      (hc_in),
    .cnt_clr    (cnt_clr),
    .data_out   (data_out),
    .data_valid (data_valid),
    .err_corr   (err_corr),
    .err_uncorr (err_uncorr),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  hamming_decoder #(.CNT_W(2)) dut_s (
    .clk        (clk),
    .arstn      (arstn),
    .in_valid   (in_valid),
    .hc_in      (hc_in),
    .cnt_clr    (cnt_clr),
    .data_out   (data_out_s),
    .data_valid (data_valid_s),
    .err_corr   (err_corr_s),
    .err_uncorr (err_uncorr_s),
    .corr_cnt   (corr_cnt_s),
    .uncorr_cnt (uncorr_cnt_s)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: data fills non-power-of-two positions, parity p covers positions with bit p set.
  function automatic logic [11:0] encode(input logic [7:0] d);
    logic [11:0] cw;
    logic        par;
    int          j;
    cw = '0;
    j  = 0;
    for (int pos = 1; pos <= 12; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos-1] = d[j];
        j++;
      end
    end
    for (int p = 0; p < 4; p++) begin
      par = 1'b0;
      for (int pos = 1; pos <= 12; pos++) begin
        if (((pos >> p) & 1) == 1) par = par ^ cw[pos-1];
      end
      cw[(1 << p) - 1] = par;
    end
    return cw;
  endfunction

  function automatic int sat_inc(input int v, input int maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [11:0] cw, input logic [7:0] d, input logic c,
                       input logic u, input logic clr);
    in_valid = 1'b1;
    hc_in    = cw;
    cnt_clr  = clr;
    exp_q.push_back({16'(cyc + 2), c, u, d});
  endtask

  task automatic send(input logic [11:0] cw, input logic [7:0] d, input logic c,
                      input logic u, input logic clr);
    @(negedge clk);
    drive(cw, d, c, u, clr);
  endtask

  task automatic idle(input int n, input logic clr);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      cnt_clr  = (i == 0) ? clr : 1'b0;
    end
  endtask

  task automatic reset_models();
    exp_q.delete();
    m_corr16  = 0;
    m_unc16   = 0;
    m_corr2   = 0;
    m_unc2    = 0;
    last_data = '0;
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(posedge clk) begin
    logic [25:0] e;
    logic        inc_c, inc_u;
    #1;
    cyc++;
    if (arstn) begin
      inc_c = 1'b0;
      inc_u = 1'b0;
      if (exp_q.size() > 0 && exp_q[0][25:10] == cyc[15:0]) begin
        e = exp_q.pop_front();
        check("valid",       32'(data_valid),   32'd1);
        check("data",        32'(data_out),     32'(e[7:0]));
        check("err_corr",    32'(err_corr),     32'(e[9]));
        check("err_uncorr",  32'(err_uncorr),   32'(e[8]));
        check("valid_s",     32'(data_valid_s), 32'd1);
        check("data_s",      32'(data_out_s),   32'(e[7:0]));
        check("err_corr_s",  32'(err_corr_s),   32'(e[9]));
        last_data = e[7:0];
        inc_c = e[9];
        inc_u = e[8];
      end else begin
        check("idle_valid",  32'(data_valid),   32'd0);
        check("idle_corr",   32'(err_corr),     32'd0);
        check("idle_uncorr", 32'(err_uncorr),   32'd0);
        check("idle_hold",   32'(data_out),     32'(last_data));
        check("idle_valid_s", 32'(data_valid_s), 32'd0);
      end
      if (cnt_clr) begin
        m_corr16 = 0; m_unc16 = 0; m_corr2 = 0; m_unc2 = 0;
      end else begin
        if (inc_c) begin
          m_corr16 = sat_inc(m_corr16, 65535);
          m_corr2  = sat_inc(m_corr2, 3);
        end
        if (inc_u) begin
          m_unc16 = sat_inc(m_unc16, 65535);
          m_unc2  = sat_inc(m_unc2, 3);
        end
      end
      check("corr_cnt",     32'(corr_cnt),     32'(m_corr16));
      check("uncorr_cnt",   32'(uncorr_cnt),   32'(m_unc16));
      check("corr_cnt_s",   32'(corr_cnt_s),   32'(m_corr2));
      check("uncorr_cnt_s", 32'(uncorr_cnt_s), 32'(m_unc2));
    end
  end

  // ---------------- directed steps ----------------
  initial begin
    logic [7:0] d;
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    arstn    = 1'b0;
    in_valid = 1'b0;
    hc_in    = '0;
    cnt_clr  = 1'b0;
    reset_models();

    // Reset state
    #3;
    check("rst_valid",  32'(data_valid), 32'd0);
    check("rst_data",   32'(data_out),   32'd0);
    check("rst_corr",   32'(err_corr),   32'd0);
    check("rst_uncorr", 32'(err_uncorr), 32'd0);
    check("rst_cnt",    32'(corr_cnt),   32'd0);
    repeat (2) @(negedge clk);

    // Clean word presented on the release edge
    arstn = 1'b1;
    drive(12'hA27, 8'hA5, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);

    // Single error at bit 6 (S=7)
    send(12'hA67, 8'hA5, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);
    check("single_err_cnt", 32'(corr_cnt), 32'd1);

    // Every single-bit flip of a few random bytes
    for (int r = 0; r < 3; r++) begin
      d = 8'($urandom_range(0, 255));
      for (int k = 0; k < 12; k++) begin
        send(encode(d) ^ (12'(1) << k), d, 1'b1, 1'b0, 1'b0);
      end
    end

    // Uncorrectable syndrome, then the legal all-zero codeword
    send(12'h226, 8'h25, 1'b0, 1'b1, 1'b0);
    send(12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    check("uncorr_cnt_one", 32'(uncorr_cnt), 32'd1);

    // Streaming: 256 back-to-back corrected words after a clear
    idle(2, 1'b1);
    for (int i = 0; i < 256; i++) begin
      send(encode(8'(i)) ^ (12'(1) << (i % 12)), 8'(i), 1'b1, 1'b0, 1'b0);
    end
    idle(3, 1'b0);
    check("stream_cnt", 32'(corr_cnt), 32'd256);

    // Saturation of the 2-bit counter, then clear on the same edge as a correction
    idle(2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send(encode(8'(8'h10 + i)) ^ 12'h004, 8'(8'h10 + i), 1'b1, 1'b0, 1'b0);
    end
    idle(3, 1'b0);
    check("sat_cnt_s", 32'(corr_cnt_s), 32'd3);
    check("sat_cnt",   32'(corr_cnt),   32'd5);
    send(encode(8'h77) ^ 12'h100, 8'h77, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    cnt_clr  = 1'b1;
    idle(2, 1'b0);
    check("clr_cnt_s", 32'(corr_cnt_s), 32'd0);
    check("clr_cnt",   32'(corr_cnt),   32'd0);

    // Reset mid-stream: one word on the outputs, one in stage 1
    send(encode(8'h3C) ^ 12'h010, 8'h3C, 1'b1, 1'b0, 1'b0);
    send(encode(8'hC3), 8'hC3, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    arstn = 1'b0;
    reset_models();
    #1;
    check("mid_rst_valid",  32'(data_valid), 32'd0);
    check("mid_rst_data",   32'(data_out),   32'd0);
    check("mid_rst_corr",   32'(err_corr),   32'd0);
    check("mid_rst_cnt",    32'(corr_cnt),   32'd0);
    check("mid_rst_cnt_s",  32'(corr_cnt_s), 32'd0);
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    drive(encode(8'h5A) ^ 12'h800, 8'h5A, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
